// File: rtl/simmem_pkg.sv
// Shared constants and types for the simulated memory controller.
// The write-response bank stores one wresp_slot_t per in-flight write burst.
package simmem_pkg;

    localparam int unsigned WriteRespBankCapacity  = 8;
    localparam int unsigned WriteRespBankAddrWidth = $clog2(WriteRespBankCapacity);
    localparam int unsigned WriteRespIdWidth       = 4;
    localparam int unsigned WriteRespWidth         = 2;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        RSVD   = 2'd1,
        FILLED = 2'd2
    } wresp_slot_state_e;

    typedef struct packed {
        wresp_slot_state_e             state;
        logic [WriteRespIdWidth-1:0]   id;
        logic [WriteRespWidth-1:0]     resp;
    } wresp_slot_t;

endpackage

// File: rtl/simmem_age_matrix.sv
// Reservation-order tracker: older[i][j] = 1 when slot i entered before slot j.
// Picks the oldest slot out of each of NumReq request masks.
module simmem_age_matrix #(
    parameter int unsigned NumSlots = 8,
    parameter int unsigned NumReq   = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumSlots-1:0]                insert_onehot_i,
    input  logic [NumSlots-1:0]                remove_onehot_i,
    input  logic [NumReq-1:0][NumSlots-1:0]    req_mask_i,
    output logic [NumReq-1:0][NumSlots-1:0]    oldest_onehot_o,
    output logic [NumSlots-1:0][NumSlots-1:0]  older_o
);

    logic [NumSlots-1:0]               valid_q, valid_d;
    logic [NumSlots-1:0][NumSlots-1:0] older_q, older_d;
    logic [NumSlots-1:0][NumSlots-1:0] older_col;

    always_comb begin
        valid_d = (valid_q & ~remove_onehot_i) | insert_onehot_i;
        older_d = older_q;
        for (int i = 0; i < NumSlots; i++) begin
            for (int j = 0; j < NumSlots; j++) begin
                if (remove_onehot_i[i] || remove_onehot_i[j] || insert_onehot_i[i]) begin
                    older_d[i][j] = 1'b0;
                end
                // every surviving occupant predates the newcomer
                if (insert_onehot_i[j] && valid_q[i] && !remove_onehot_i[i]) begin
                    older_d[i][j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            for (int j = 0; j < NumSlots; j++) begin
                older_col[i][j] = older_q[j][i];
            end
        end
    end

    always_comb begin
        oldest_onehot_o = '0;
        for (int r = 0; r < NumReq; r++) begin
            for (int i = 0; i < NumSlots; i++) begin
                oldest_onehot_o[r][i] = req_mask_i[r][i] && !(|(req_mask_i[r] & older_col[i]));
            end
        end
    end

    assign older_o = older_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            older_q <= '0;
        end else begin
            valid_q <= valid_d;
            older_q <= older_d;
        end
    end

endmodule

// File: rtl/simmem_wresp_bank.sv
// Write-response bank: reserves a slot per write burst, stores the B response,
// and returns it once the delay calculator enables that slot, oldest first.
module simmem_wresp_bank
    import simmem_pkg::*;
#(
    parameter int unsigned NumSlots  = WriteRespBankCapacity,
    parameter int unsigned IidWidth  = $clog2(NumSlots),
    parameter int unsigned IdWidth   = WriteRespIdWidth,
    parameter int unsigned RespWidth = WriteRespWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rsv_valid_i,
    input  logic [IdWidth-1:0]   rsv_id_i,
    output logic                 rsv_ready_o,
    output logic [IidWidth-1:0]  rsv_iid_o,
    input  logic                 in_valid_i,
    input  logic [IdWidth-1:0]   in_id_i,
    input  logic [RespWidth-1:0] in_resp_i,
    output logic                 in_ready_o,
    input  logic [NumSlots-1:0]  release_en_i,
    output logic [NumSlots-1:0]  released_addr_onehot_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IdWidth-1:0]   out_id_o,
    output logic [RespWidth-1:0] out_resp_o
);

    wresp_slot_t [NumSlots-1:0]        slot_q, slot_d;
    logic [NumSlots-1:0]               released_q, released_d;
    logic                              hold_q, hold_d;
    logic [NumSlots-1:0]               hold_sel_q, hold_sel_d;

    logic [NumSlots-1:0]               free, rsvd, filled;
    logic [NumSlots-1:0]               lowest_free, rsv_onehot;
    logic [NumSlots-1:0]               fill_cand, fill_onehot;
    logic [NumSlots-1:0]               same_id_blk, elig;
    logic [NumSlots-1:0]               sel_onehot, rel_onehot;
    logic [1:0][NumSlots-1:0]          req_mask, oldest;
    logic [NumSlots-1:0][NumSlots-1:0] older;
    logic                              out_fire;

    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            free[i]   = (slot_q[i].state == FREE);
            rsvd[i]   = (slot_q[i].state == RSVD);
            filled[i] = (slot_q[i].state == FILLED);
        end
    end

    always_comb begin
        lowest_free = '0;
        rsv_iid_o   = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (free[i]) begin
                lowest_free = '0;
                lowest_free[i] = 1'b1;
                rsv_iid_o = IidWidth'(i);
            end
        end
    end

    assign rsv_ready_o = |free;
    assign rsv_onehot  = rsv_valid_i ? lowest_free : '0;

    // Same-ID ordering: a slot waits while any older live slot shares its ID.
    always_comb begin
        same_id_blk = '0;
        fill_cand   = '0;
        for (int i = 0; i < NumSlots; i++) begin
            fill_cand[i] = rsvd[i] && (IdWidth'(slot_q[i].id) == in_id_i);
            for (int j = 0; j < NumSlots; j++) begin
                if (older[j][i] && !free[j] && (slot_q[j].id == slot_q[i].id)) begin
                    same_id_blk[i] = 1'b1;
                end
            end
        end
    end

    assign elig        = filled & release_en_i & ~same_id_blk;
    assign req_mask[0] = fill_cand;
    assign req_mask[1] = elig;

    simmem_age_matrix #(
        .NumSlots (NumSlots),
        .NumReq   (2)
    ) u_age (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .insert_onehot_i (rsv_onehot),
        .remove_onehot_i (rel_onehot),
        .req_mask_i      (req_mask),
        .oldest_onehot_o (oldest),
        .older_o         (older)
    );

    assign in_ready_o  = |fill_cand;
    assign fill_onehot = in_valid_i ? oldest[0] : '0;

    // A presented response stays put until taken, even if an older slot wakes up.
    assign sel_onehot  = hold_q ? hold_sel_q : oldest[1];
    assign out_valid_o = hold_q || (|elig);
    assign out_fire    = out_valid_o && out_ready_i;
    assign rel_onehot  = out_fire ? sel_onehot : '0;

    always_comb begin
        out_id_o   = '0;
        out_resp_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (sel_onehot[i]) begin
                out_id_o   |= IdWidth'(slot_q[i].id);
                out_resp_o |= RespWidth'(slot_q[i].resp);
            end
        end
    end

    always_comb begin
        hold_d     = out_valid_o && !out_ready_i;
        hold_sel_d = hold_d ? sel_onehot : '0;
        released_d = rel_onehot;
        slot_d     = slot_q;
        for (int i = 0; i < NumSlots; i++) begin
            if (rel_onehot[i]) begin
                slot_d[i].state = FREE;
            end
            if (fill_onehot[i]) begin
                slot_d[i].state = FILLED;
                slot_d[i].resp  = WriteRespWidth'(in_resp_i);
            end
            if (rsv_onehot[i]) begin
                slot_d[i].state = RSVD;
                slot_d[i].id    = WriteRespIdWidth'(rsv_id_i);
                slot_d[i].resp  = '0;
            end
        end
    end

    assign released_addr_onehot_o = released_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q     <= '0;
            released_q <= '0;
            hold_q     <= 1'b0;
            hold_sel_q <= '0;
        end else begin
            slot_q     <= slot_d;
            released_q <= released_d;
            hold_q     <= hold_d;
            hold_sel_q <= hold_sel_d;
        end
    end

    // The enable bit of a just-released slot is still set during its pulse cycle.
    a_fill_not_free : assert property (@(posedge clk_i) disable iff (rst_i)
        (fill_onehot & free) == '0);
    a_release_en_not_free : assert property (@(posedge clk_i) disable iff (rst_i)
        (release_en_i & free & ~released_q) == '0);

endmodule

// File: tb/tb_simmem_wresp_bank.sv
// Directed bench for simmem_wresp_bank with a slot/sequence-number reference model.
module tb_simmem_wresp_bank;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rsv_valid;
    logic [3:0] rsv_id;
    logic       rsv_ready;
    logic [2:0] rsv_iid;
    logic       in_valid;
    logic [3:0] in_id;
    logic [1:0] in_resp;
    logic       in_ready;
    logic [7:0] rel_en;
    logic [7:0] released;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_id;
    logic [1:0] out_resp;

    int checks   = 0;
    int failures = 0;

    // model: 0 free, 1 reserved, 2 filled; seq orders reservations
    int         m_st[N];
    int         m_id[N];
    int         m_resp[N];
    int         m_seq[N];
    int         seq_ctr;
    int         m_hold;
    logic [7:0] m_pulse;

    always #5 clk = ~clk;

    simmem_wresp_bank dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .rsv_valid_i            (rsv_valid),
        .rsv_id_i               (rsv_id),
        .rsv_ready_o            (rsv_ready),
        .rsv_iid_o              (rsv_iid),
        .in_valid_i             (in_valid),
        .in_id_i                (in_id),
        .in_resp_i              (in_resp),
        .in_ready_o             (in_ready),
        .release_en_i           (rel_en),
        .released_addr_onehot_o (released),
        .out_valid_o            (out_valid),
        .out_ready_i            (out_ready),
        .out_id_o               (out_id),
        .out_resp_o             (out_resp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_id[i] = 0; m_resp[i] = 0; m_seq[i] = 0;
        end
        seq_ctr = 0;
        m_hold  = -1;
        m_pulse = '0;
    endfunction

    function automatic int m_free_slot();
        for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
        return -1;
    endfunction

    function automatic int m_fill_target(input int id);
        int best = -1;
        for (int i = 0; i < N; i++)
            if (m_st[i] == 1 && m_id[i] == id && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        return best;
    endfunction

    function automatic bit m_elig(input int i);
        if (m_st[i] != 2 || !rel_en[i]) return 1'b0;
        for (int j = 0; j < N; j++)
            if (j != i && m_st[j] != 0 && m_id[j] == m_id[i] && m_seq[j] < m_seq[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_sel();
        int best = -1;
        if (m_hold >= 0) return m_hold;
        for (int i = 0; i < N; i++)
            if (m_elig(i) && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        return best;
    endfunction

    // Compare every DUT output against the model at the falling edge.
    task automatic sample();
        int ri, fi, sel;
        @(negedge clk);
        ri  = m_free_slot();
        fi  = m_fill_target(int'(in_id));
        sel = m_sel();
        chk("rsv_ready", rsv_ready, ri >= 0);
        if (ri >= 0) chk("rsv_iid", rsv_iid, ri);
        chk("in_ready", in_ready, fi >= 0);
        chk("out_valid", out_valid, sel >= 0);
        if (sel >= 0) begin
            chk("out_id", out_id, m_id[sel]);
            chk("out_resp", out_resp, m_resp[sel]);
        end
        chk("released", released, m_pulse);
    endtask

    // Advance the model with the current inputs, then cross the rising edge.
    // The DUT's release pulse is folded into rel_en like the delay calculator does.
    task automatic advance();
        int ri, fi, sel;
        logic [7:0] pend;
        ri  = m_free_slot();
        fi  = m_fill_target(int'(in_id));
        sel = m_sel();
        if (rst) begin
            m_reset();
        end else begin
            m_pulse = (sel >= 0 && out_ready) ? (8'h01 << sel) : 8'h00;
            m_hold  = (sel >= 0 && !out_ready) ? sel : -1;
            if (sel >= 0 && out_ready) m_st[sel] = 0;
            if (in_valid && fi >= 0) begin
                m_st[fi] = 2; m_resp[fi] = int'(in_resp);
            end
            if (rsv_valid && ri >= 0) begin
                m_st[ri] = 1; m_id[ri] = int'(rsv_id); m_seq[ri] = seq_ctr; seq_ctr++;
            end
        end
        pend = released;
        @(posedge clk);
        #1;
        rel_en = rel_en ^ pend;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        rst = 1'b1; rsv_valid = 1'b0; rsv_id = '0; in_valid = 1'b0; in_id = '0;
        in_resp = '0; rel_en = '0; out_ready = 1'b0;
        m_reset();
        sample();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_rsv_ready", rsv_ready, 1'b1);
        chk("reset_rsv_iid", rsv_iid, 3'd0);
        chk("reset_in_ready", in_ready, 1'b0);
        advance();
        rst = 1'b0;

        // single burst, ID 3
        rsv_valid = 1'b1; rsv_id = 4'd3;
        sample(); chk("t1_rsv_iid", rsv_iid, 3'd0); advance();
        rsv_valid = 1'b0;
        in_valid = 1'b1; in_id = 4'd3; in_resp = 2'b00; rel_en = 8'h01; out_ready = 1'b1;
        sample(); chk("t1_in_ready", in_ready, 1'b1); chk("t1_no_out_yet", out_valid, 1'b0); advance();
        in_valid = 1'b0;
        sample(); chk("t1_out_valid", out_valid, 1'b1); chk("t1_out_id", out_id, 4'd3);
        chk("t1_out_resp", out_resp, 2'd0); advance();
        sample(); chk("t1_pulse", released, 8'h01); chk("t1_out_done", out_valid, 1'b0); advance();
        sample(); chk("t1_pulse_gone", released, 8'h00); advance();

        // two bursts with the same ID keep their order
        rsv_valid = 1'b1; rsv_id = 4'd5;
        step(); step();
        rsv_valid = 1'b0;
        in_valid = 1'b1; in_id = 4'd5; in_resp = 2'd1; step();
        in_resp = 2'd2; step();
        in_valid = 1'b0; rel_en = 8'h02;
        sample(); chk("t2_blocked", out_valid, 1'b0); advance();
        step();
        rel_en = rel_en | 8'h01;
        sample(); chk("t2_first_id", out_id, 4'd5); chk("t2_first_resp", out_resp, 2'd1); advance();
        sample(); chk("t2_pulse0", released, 8'h01); chk("t2_second_resp", out_resp, 2'd2); advance();
        sample(); chk("t2_pulse1", released, 8'h02); advance();
        step();

        // different IDs may reorder
        rsv_valid = 1'b1; rsv_id = 4'd1; step();
        rsv_id = 4'd2; step();
        rsv_valid = 1'b0;
        in_valid = 1'b1; in_id = 4'd1; in_resp = 2'd3; step();
        in_id = 4'd2; in_resp = 2'd1; step();
        in_valid = 1'b0; rel_en = 8'h02;
        sample(); chk("t3_id2_first", out_id, 4'd2); advance();
        sample(); chk("t3_pulse1", released, 8'h02); chk("t3_id1_waits", out_valid, 1'b0); advance();
        rel_en = rel_en | 8'h01;
        sample(); chk("t3_id1", out_id, 4'd1); chk("t3_id1_resp", out_resp, 2'd3); advance();
        step(); step();

        // response with no matching reservation is back-pressured
        in_valid = 1'b1; in_id = 4'd7; in_resp = 2'd2;
        sample(); chk("t5_no_match", in_ready, 1'b0); advance();
        in_valid = 1'b0;
        step();

        // fill the bank, then free slot 4
        rsv_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            rsv_id = 4'(i);
            step();
        end
        rsv_valid = 1'b0;
        sample(); chk("t4_full", rsv_ready, 1'b0); advance();
        in_valid = 1'b1; in_id = 4'd4; in_resp = 2'd2; step();
        in_valid = 1'b0; rel_en = 8'h10;
        sample(); chk("t4_out_id", out_id, 4'd4); chk("t4_still_full", rsv_ready, 1'b0); advance();
        sample(); chk("t4_ready_again", rsv_ready, 1'b1); chk("t4_iid", rsv_iid, 3'd4);
        chk("t4_pulse", released, 8'h10); advance();

        // stalled output must not be preempted by an older slot
        rsv_valid = 1'b1; rsv_id = 4'd9; step();
        rsv_valid = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_id = 4'd9; in_resp = 2'd1; rel_en = rel_en | 8'h10; step();
        in_valid = 1'b0;
        sample(); chk("t6_present", out_id, 4'd9); advance();
        in_valid = 1'b1; in_id = 4'd0; in_resp = 2'd3; rel_en = rel_en | 8'h01; step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample(); chk("t6_hold_id", out_id, 4'd9); chk("t6_hold_resp", out_resp, 2'd1); advance();
        end
        rst = 1'b1; rel_en = 8'h00;
        step();
        rst = 1'b0;
        sample(); chk("t6_rst_valid", out_valid, 1'b0); chk("t6_rst_rsv", rsv_ready, 1'b1);
        chk("t6_rst_iid", rsv_iid, 3'd0); chk("t6_rst_pulse", released, 8'h00);
        chk("t6_rst_in_ready", in_ready, 1'b0); advance();

        // reserve, fill and release in the same cycle
        out_ready = 1'b1;
        rsv_valid = 1'b1; rsv_id = 4'd1; step(); step();
        in_valid = 1'b1; in_id = 4'd1; in_resp = 2'd1; rsv_id = 4'd3; step();
        rel_en = 8'h01; in_resp = 2'd2; rsv_id = 4'd4;
        sample(); chk("t7_out_id", out_id, 4'd1); chk("t7_iid", rsv_iid, 3'd3); advance();
        rsv_valid = 1'b0; in_valid = 1'b0; rel_en = rel_en | 8'h02;
        sample(); chk("t7_second_resp", out_resp, 2'd2); advance();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simmem_wresp_bank.md
Name: simmem_wresp_bank

Overview:
- Write-response bank of the simulated memory controller.
- Holds one slot per in-flight write burst and receives B responses from the real memory.
- Returns each response to the requester only after the delay calculator raises that slot's release enable.
- On every release it returns a one-cycle one-hot feedback pulse, which the delay calculator XORs into its release-enable register.

Parameters:
- NumSlots, 8, slot count (equals simmem_pkg::WriteRespBankCapacity); also the width of the release vectors.
- IidWidth, $clog2(NumSlots), internal identifier (slot index) width.
- IdWidth, 4, AXI BID width.
- RespWidth, 2, BRESP payload width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rsv_valid_i  in  1  write address accepted; reserve a slot
- rsv_id_i  in  IdWidth  AXI ID of the reserved burst
- rsv_ready_o  out  1  a free slot exists
- rsv_iid_o  out  IidWidth  slot index granted; forwarded to the delay calculator as waddr_iid
- in_valid_i  in  1  B response from real memory
- in_id_i  in  IdWidth  its ID
- in_resp_i  in  RespWidth  its BRESP
- in_ready_o  out  1  response can be stored
- release_en_i  in  NumSlots  per-slot release enable from the delay calculator
- released_addr_onehot_o  out  NumSlots  one-cycle pulse marking the slot just released
- out_valid_o  out  1  response to requester valid
- out_ready_i  in  1  requester ready
- out_id_o  out  IdWidth  released BID
- out_resp_o  out  RespWidth  released BRESP

Behaviour:
- Per-slot state, registered: st in {FREE, RSVD, FILLED}; id; resp.
- Age matrix: older[i][j] = 1 means slot i was reserved before slot j.
- Reset (rst_i high at a clock edge): all slots FREE; age matrix cleared; released_addr_onehot_o = 0.
  - The combinational outputs then evaluate to: out_valid_o = 0, in_ready_o = 0, rsv_ready_o = 1, rsv_iid_o = 0.
  - Reset mid-operation discards all slots with no release pulses.
- Reservation:
  - rsv_ready_o = any slot FREE in the current state.
  - rsv_iid_o = lowest-index FREE slot (combinational).
  - On rsv_valid_i && rsv_ready_o: that slot becomes RSVD with id = rsv_id_i at the next edge.
  - The age matrix marks every non-FREE slot as older than the new slot.
  - When all NumSlots slots are non-FREE, rsv_ready_o = 0.
- Fill:
  - Target = the oldest RSVD slot whose id == in_id_i.
  - in_ready_o = target exists. in_ready_o may depend on in_id_i; no RSVD match means in_ready_o = 0, i.e. back-pressure.
  - On handshake: target becomes FILLED with resp = in_resp_i.
  - A slot reserved in the same cycle is not a fill target; it becomes eligible from the next cycle.
- Eligibility: slot is FILLED, release_en_i[slot] = 1, and no older non-FREE slot carries the same id. This keeps same-ID order.
  - release_en_i may rise before or after the fill. The slot waits until both hold.
- Output:
  - out_valid_o = any eligible slot; the oldest eligible slot is selected (age matrix).
  - out_id_o and out_resp_o come from the selected slot, combinational from registers.
  - Once asserted, out_valid_o and its payload stay stable until the handshake. A newly eligible older slot of a different ID must not preempt: the selection is latched in a hold register while out_valid_o && !out_ready_i.
- Release:
  - On an out handshake, the slot goes to FREE at the next edge.
  - released_addr_onehot_o = onehot(slot) for exactly that one following cycle, then 0.
  - At most one release per cycle.
  - A slot freed by a release is not reservable in the same cycle as the handshake (free set taken from current state).
- Simultaneous events: reserve, fill and release in one cycle are independent and all take effect. Fill and release always target different slots.
- Error conditions (flag with assertions, no recovery): fill to a FREE slot; release_en_i set on a FREE slot.

Decomposition:
- simmem_pkg additions: wresp_slot_state_e enum {FREE, RSVD, FILLED}; wresp_slot_t packed struct {state, id, resp}.
- Reuse the existing WriteRespBankCapacity and WriteRespBankAddrWidth from simmem_pkg.
- One sub-module, simmem_age_matrix: NumSlots-parameterised, with an insert onehot, a remove onehot, and an oldest-of-request-mask onehot output. It is used for both fill-target selection and output selection.

Test Plan:
- Reset, then reserve ID 3: rsv_iid_o = 0 → slot 0 RSVD. Fill ID 3 with resp 2'b00, then release_en_i = 8'h01, out_ready_i = 1 → out_valid_o the following cycle with id 3, resp 0; released_addr_onehot_o = 8'h01 for one cycle.
- Reserve IDs 5 and 5 (slots 0 and 1). Fill both, raise release_en_i = 8'h02 only → out_valid_o stays 0 (same-ID order). Then raise bit 0 → slot 0 released first, then slot 1.
- Reserve IDs 1 and 2, fill both, set release_en_i = 8'h02 → ID 2 released before ID 1 (cross-ID reordering allowed).
- Reserve 8 times → rsv_ready_o = 0. Release slot 4 → rsv_ready_o = 1 one cycle after the handshake, rsv_iid_o = 4.
- Fill with in_id_i = 7 and no RSVD slot of ID 7 → in_ready_o = 0, nothing stored.
- Hold out_ready_i = 0 for 3 cycles while an older slot becomes eligible → out_id_o and out_resp_o stable. Assert rst_i mid-stream → all outputs return to reset values next cycle, no released pulse.
